// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: one request at a time,
// fixed access latency, RV32I byte/half/word sizing and error flagging.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic          lat_we;
  logic [2:0]    lat_funct3;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_we;
  logic [2:0]    cur_funct3;
  logic          accept;
  logic          go_resp;
  logic          misaligned;
  logic          bad_funct3;
  logic          out_of_range;
  logic          bad;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wd;

  // With LATENCY = 1 the access happens at the accept edge itself, so the
  // request is taken straight from the inputs while still in IDLE.
  always_comb begin
    cur_addr   = lat_addr;
    cur_wdata  = lat_wdata;
    cur_we     = lat_we;
    cur_funct3 = lat_funct3;
    if (state == IDLE) begin
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
      cur_we     = req_we;
      cur_funct3 = req_funct3;
    end
  end

  assign accept  = (state == IDLE) && req_valid && req_ready;
  assign go_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));

  always_comb begin
    misaligned = 1'b0;
    bad_funct3 = 1'b0;
    case (cur_funct3)
      3'b000: misaligned = 1'b0;
      3'b001: misaligned = cur_addr[0];
      3'b010: misaligned = |cur_addr[1:0];
      3'b100: bad_funct3 = cur_we;
      3'b101: begin
        bad_funct3 = cur_we;
        misaligned = cur_addr[0];
      end
      default: bad_funct3 = 1'b1;
    endcase
  end

  assign out_of_range = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign bad          = misaligned | bad_funct3 | out_of_range;
  assign idx          = cur_addr[AW+1:2];
  assign rd_word      = mem[idx];

  always_comb begin
    rd_byte   = rd_word[8*cur_addr[1:0] +: 8];
    rd_half   = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0;
    case (cur_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be = 4'b0000;
    wd = cur_wdata;
    case (cur_funct3)
      3'b000: begin
        be = 4'b0001 << cur_addr[1:0];
        wd = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        be = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && go_resp && cur_we && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            req_ready  <= 1'b0;
            if (go_resp) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= bad;
              resp_rdata <= (bad || cur_we) ? 32'h0 : load_data;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (go_resp) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= bad;
            resp_rdata <= (bad || cur_we) ? 32'h0 : load_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
